// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the fetch stage
// and the pipeline registers that reuse ifid_reg.
package fetch_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] RESET_PC  = 32'h0000_0000;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [XLEN-1:0] PC_STEP   = 32'd4;

    typedef enum logic [1:0] {
        FETCH,
        HOLD,
        DISCARD
    } state_t;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_plus4;
        logic            valid;
    } ifid_t;

    localparam ifid_t IFID_BUBBLE = '{
        instr:    NOP_INSTR,
        pc:       '0,
        pc_plus4: '0,
        valid:    1'b0
    };

endpackage

// File: rtl/fetch_if.sv
// fetch_if: single-outstanding req/ack instruction-memory port.
// master = fetch side, slave = memory side.
interface fetch_if;
    import fetch_pkg::*;

    logic            req;
    logic [XLEN-1:0] addr;
    logic            ack;
    logic [XLEN-1:0] rdata;

    modport master (
        output req,
        output addr,
        input  ack,
        input  rdata
    );

    modport slave (
        input  req,
        input  addr,
        output ack,
        output rdata
    );

endinterface

// File: rtl/ifid_reg.sv
// ifid_reg: generic pipeline register with
// reset > flush > stall > load/bubble priority.
module ifid_reg
    import fetch_pkg::*;
#(
    parameter type T      = ifid_t,
    parameter T    BUBBLE = IFID_BUBBLE
) (
    input  logic clk,
    input  logic reset,
    input  logic flush,
    input  logic stall,
    input  logic load,
    input  T     d,
    output T     q
);

    // Flush and bubble share the same value; stall holds.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            q <= BUBBLE;
        end else if (!stall) begin
            q <= load ? d : BUBBLE;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC, imem request FSM, response buffer and IF/ID register.
// Memory wait states become bubbles; downstream stages never stall.
module fetch_unit
    import fetch_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            StallF,
    input  logic            StallD,
    input  logic            FlushD,
    input  logic            PCSrcE,
    input  logic [XLEN-1:0] PCTargetE,
    fetch_if.master         imem,
    output logic [XLEN-1:0] InstrD,
    output logic [XLEN-1:0] PCD,
    output logic [XLEN-1:0] PCPlus4D,
    output logic            ValidD
);

    state_t          state, state_n;
    logic [XLEN-1:0] pcf, pcf_n;
    logic [XLEN-1:0] req_addr, req_addr_n;
    logic [XLEN-1:0] buf_instr, buf_instr_n;
    logic [XLEN-1:0] buf_pc, buf_pc_n;
    logic            hold;
    logic            ifid_load;
    ifid_t           ifid_d, ifid_q;

    assign hold = StallF | StallD;

    // The request is parked only in HOLD; reset drops it immediately.
    assign imem.req  = !reset && (state != HOLD);
    assign imem.addr = req_addr;

    // State, PC, request address and response buffer.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= FETCH;
            pcf       <= RESET_PC;
            req_addr  <= RESET_PC;
            buf_instr <= NOP_INSTR;
            buf_pc    <= '0;
        end else begin
            state     <= state_n;
            pcf       <= pcf_n;
            req_addr  <= req_addr_n;
            buf_instr <= buf_instr_n;
            buf_pc    <= buf_pc_n;
        end
    end

    // Next state, next PC and what goes into IF/ID.
    always_comb begin
        state_n     = state;
        pcf_n       = pcf;
        req_addr_n  = req_addr;
        buf_instr_n = buf_instr;
        buf_pc_n    = buf_pc;
        ifid_load   = 1'b0;
        ifid_d      = '{
            instr:    imem.rdata,
            pc:       req_addr,
            pc_plus4: req_addr + PC_STEP,
            valid:    1'b1
        };
        unique case (state)
            FETCH: begin
                if (imem.ack) begin
                    if (PCSrcE) begin
                        pcf_n      = PCTargetE;
                        req_addr_n = PCTargetE;
                    end else if (hold) begin
                        buf_instr_n = imem.rdata;
                        buf_pc_n    = req_addr;
                        state_n     = HOLD;
                    end else begin
                        ifid_load  = 1'b1;
                        pcf_n      = req_addr + PC_STEP;
                        req_addr_n = req_addr + PC_STEP;
                    end
                end else if (PCSrcE) begin
                    // Address must stay stable until the old ack.
                    pcf_n   = PCTargetE;
                    state_n = DISCARD;
                end
            end
            HOLD: begin
                if (PCSrcE) begin
                    pcf_n      = PCTargetE;
                    req_addr_n = PCTargetE;
                    state_n    = FETCH;
                end else if (!hold) begin
                    ifid_load  = 1'b1;
                    ifid_d     = '{
                        instr:    buf_instr,
                        pc:       buf_pc,
                        pc_plus4: buf_pc + PC_STEP,
                        valid:    1'b1
                    };
                    pcf_n      = buf_pc + PC_STEP;
                    req_addr_n = buf_pc + PC_STEP;
                    state_n    = FETCH;
                end
            end
            DISCARD: begin
                if (PCSrcE) begin
                    pcf_n = PCTargetE;
                end
                if (imem.ack) begin
                    req_addr_n = PCSrcE ? PCTargetE : pcf;
                    state_n    = FETCH;
                end
            end
            default: begin
                state_n = FETCH;
            end
        endcase
    end

    ifid_reg #(
        .T      (ifid_t),
        .BUBBLE (IFID_BUBBLE)
    ) u_ifid (
        .clk   (clk),
        .reset (reset),
        .flush (FlushD),
        .stall (StallD),
        .load  (ifid_load),
        .d     (ifid_d),
        .q     (ifid_q)
    );

    assign InstrD   = ifid_q.instr;
    assign PCD      = ifid_q.pc;
    assign PCPlus4D = ifid_q.pc_plus4;
    assign ValidD   = ifid_q.valid;

endmodule
